// File: rtl/pass_sequencer.sv
// pass_sequencer: steps the datapath through up to NUM_PASSES ordered passes.
// Each pass ends on end_check_i or aborts on a per-pass cycle timeout.
// Passes are separated by a one-cycle all-zero gap. ERR is sticky until clear_i.
module pass_sequencer #(
    parameter int NUM_PASSES = 3,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  init_i,
    input  logic                  clear_i,
    input  logic                  end_check_i,
    input  logic [IDX_W-1:0]      last_pass_i,
    input  logic [CNT_W-1:0]      pass_len_i,
    output logic [NUM_PASSES-1:0] pass_o,
    output logic [IDX_W-1:0]      pass_idx_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [2:0]            curr_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        RUN  = 3'b001,
        GAP  = 3'b010,
        DONE = 3'b011,
        ERR  = 3'b100
    } state_t;

    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Held as plain bits so codes outside the enum can exist and be recovered.
    logic [2:0]       state;
    logic [IDX_W-1:0] last_pass;
    logic             timeout;

    assign curr_state_o = state;
    assign timeout      = (pass_len_i != '0) && (cycle_cnt_o == pass_len_i - CNT_W'(1));

    // Sequencer FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            last_pass   <= '0;
            pass_o      <= '0;
            pass_idx_o  <= '0;
            cycle_cnt_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (en_i) begin
            if (clear_i) begin
                state       <= IDLE;
                pass_o      <= '0;
                pass_idx_o  <= '0;
                cycle_cnt_o <= '0;
                busy_o      <= 1'b0;
                done_o      <= 1'b0;
                err_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        // Start or restart at pass 0; final index clamped to the last real pass.
                        if (init_i) begin
                            state       <= RUN;
                            last_pass   <= (last_pass_i > LAST_MAX) ? LAST_MAX : last_pass_i;
                            pass_o      <= NUM_PASSES'(1);
                            pass_idx_o  <= '0;
                            cycle_cnt_o <= '0;
                            busy_o      <= 1'b1;
                            done_o      <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (end_check_i) begin
                            pass_o <= '0;
                            if (pass_idx_o == last_pass) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end else if (timeout) begin
                            // Index and count stay frozen for debug.
                            state  <= ERR;
                            pass_o <= '0;
                            busy_o <= 1'b0;
                            err_o  <= 1'b1;
                        end else if (cycle_cnt_o != CNT_MAX) begin
                            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        state       <= RUN;
                        pass_idx_o  <= pass_idx_o + IDX_W'(1);
                        pass_o      <= NUM_PASSES'(1) << (pass_idx_o + IDX_W'(1));
                        cycle_cnt_o <= '0;
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state       <= IDLE;
                        pass_o      <= '0;
                        pass_idx_o  <= '0;
                        cycle_cnt_o <= '0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b0;
                        err_o       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pass_sequencer.sv
// Bench for pass_sequencer: directed vector table, hand-written corner
// sequences, then randomized stimulus against a pass-level reference model.
module tb_pass_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, init = 1'b0, clr = 1'b0, ec = 1'b0;
    logic [1:0] lp = '0;
    logic [7:0] len = '0;
    logic [2:0] pass_o;
    logic [1:0] pass_idx_o;
    logic [7:0] cycle_cnt_o;
    logic       busy_o, done_o, err_o;
    logic [2:0] curr_state_o;

    int n_total = 0;
    int n_pass  = 0;

    pass_sequencer #(.NUM_PASSES(3), .CNT_W(8), .IDX_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .init_i(init), .clear_i(clr),
        .end_check_i(ec), .last_pass_i(lp), .pass_len_i(len),
        .pass_o(pass_o), .pass_idx_o(pass_idx_o), .cycle_cnt_o(cycle_cnt_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .curr_state_o(curr_state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, init, clr, ec;
        logic [1:0] lp;
        logic [7:0] len;
        int         es, ep, ei, ecnt;   // ecnt < 0: count not checked
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, i, c, x, input logic [1:0] l, input logic [7:0] n,
                       input int es, ep, ei, ecnt);
        vec_t v;
        v.en = e; v.init = i; v.clr = c; v.ec = x; v.lp = l; v.len = n;
        v.es = es; v.ep = ep; v.ei = ei; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Flags and strobe follow from the state by the specification's rules.
    task automatic chk_out(input string tag, input int es, ep, ei, ecnt);
        chk({tag, ".state"}, int'(curr_state_o), es);
        chk({tag, ".pass"},  int'(pass_o), ep);
        chk({tag, ".idx"},   int'(pass_idx_o), ei);
        if (ecnt >= 0) chk({tag, ".cnt"}, int'(cycle_cnt_o), ecnt);
        chk({tag, ".busy"},  int'(busy_o), int'(es == 1 || es == 2));
        chk({tag, ".done"},  int'(done_o), int'(es == 3));
        chk({tag, ".err"},   int'(err_o),  int'(es == 4));
    endtask

    task automatic drive(input logic e, i, c, x, input logic [1:0] l, input logic [7:0] n);
        en = e; init = i; clr = c; ec = x; lp = l; len = n;
        @(posedge clk);
        #1;
    endtask

    // Reference model: phase 0 idle, 1 running, 2 gap, 3 done, 4 error.
    int m_ph, m_idx, m_cnt, m_last;

    task automatic m_reset();
        m_ph = 0; m_idx = 0; m_cnt = 0; m_last = 0;
    endtask

    task automatic m_step();
        if (!en) return;
        if (clr) begin
            m_ph = 0; m_idx = 0; m_cnt = 0;
        end else if ((m_ph == 0 || m_ph == 3) && init) begin
            m_ph = 1; m_idx = 0; m_cnt = 0;
            m_last = (int'(lp) > 2) ? 2 : int'(lp);
        end else if (m_ph == 1) begin
            if (ec) m_ph = (m_idx == m_last) ? 3 : 2;
            else if (len != 0 && m_cnt == int'(len) - 1) m_ph = 4;
            else if (m_cnt < 255) m_cnt++;
        end else if (m_ph == 2) begin
            m_ph = 1; m_idx++; m_cnt = 0;
        end
    endtask

    initial begin
        // Test 1: three passes, no timeout, ends after 4, 2, 5 cycles.
        add(1,1,0,0,2,0, 1,1,0,0);
        for (int k = 1; k <= 3; k++) add(1,0,0,0,2,0, 1,1,0,k);
        add(1,0,0,1,2,0, 2,0,0,-1);
        add(1,0,0,0,2,0, 1,2,1,0);
        add(1,0,0,0,2,0, 1,2,1,1);
        add(1,0,0,1,2,0, 2,0,1,-1);
        add(1,0,0,0,2,0, 1,4,2,0);
        for (int k = 1; k <= 4; k++) add(1,0,0,0,2,0, 1,4,2,k);
        add(1,0,0,1,2,0, 3,0,2,-1);
        add(1,0,0,1,2,0, 3,0,2,-1);          // end_check ignored in DONE
        // Test 3: end_check on the timeout cycle wins (len 5, last pass 1).
        add(1,1,0,0,1,5, 1,1,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,0,0,1,5, 1,1,0,k);
        add(1,0,0,1,1,5, 2,0,0,-1);
        add(1,0,0,0,1,5, 1,2,1,0);
        for (int k = 1; k <= 4; k++) add(1,0,0,0,1,5, 1,2,1,k);
        add(1,0,0,1,1,5, 3,0,1,-1);
        // Test 5: last_pass 3 clamps to 2, restart from DONE, then clear.
        add(1,1,0,0,3,0, 1,1,0,0);
        add(1,0,0,1,3,0, 2,0,0,-1);
        add(1,0,0,0,3,0, 1,2,1,0);
        add(1,0,0,1,3,0, 2,0,1,-1);
        add(1,0,0,0,3,0, 1,4,2,0);
        add(1,0,0,1,3,0, 3,0,2,-1);
        add(1,1,0,0,3,0, 1,1,0,0);
        add(1,0,1,0,3,0, 0,0,0,0);
        // Test 2: timeout on the fifth RUN cycle, sticky ERR, clear.
        add(1,1,0,0,2,5, 1,1,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,0,0,2,5, 1,1,0,k);
        add(1,0,0,0,2,5, 4,0,0,4);
        add(1,1,0,0,2,5, 4,0,0,4);
        add(1,0,0,1,2,5, 4,0,0,4);
        add(1,0,1,0,2,5, 0,0,0,0);
        // Test 4: enable low freezes everything, then end_check lands.
        add(1,1,0,0,2,0, 1,1,0,0);
        add(1,0,0,0,2,0, 1,1,0,1);
        for (int k = 0; k < 3; k++) add(0,1,1,1,2,0, 1,1,0,1);
        add(1,0,0,1,2,0, 2,0,0,-1);

        // Reset state
        #12;
        chk_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        drive(1,0,0,0,0,0);
        chk_out("idle", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].init, tbl[i].clr, tbl[i].ec, tbl[i].lp, tbl[i].len);
            chk_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].ep, tbl[i].ei, tbl[i].ecnt);
        end

        // Test 6a: async reset mid-pass with enable low.
        drive(1,0,0,0,2,0);
        chk_out("pre_rst", 1, 2, 1, 0);
        en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1,0,0,0,2,0);
        chk_out("post_rst", 0, 0, 0, 0);

        // Test 6b: illegal state code recovers to IDLE.
        drive(1,1,0,0,2,0);
        drive(1,0,0,0,2,0);
        chk_out("pre_ill", 1, 1, 0, 1);
        force dut.state = 3'b110;
        #1 release dut.state;
        drive(1,0,0,0,2,0);
        chk_out("illegal", 0, 0, 0, 0);

        // Counter saturation with no timeout.
        drive(1,1,0,0,2,0);
        for (int k = 0; k < 300; k++) drive(1,0,0,0,2,0);
        chk_out("sat", 1, 1, 0, 255);

        // Randomized run against the model.
        rst = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            en   = ($urandom_range(0, 9) != 0);
            init = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            ec   = ($urandom_range(0, 4) == 0);
            lp   = 2'($urandom_range(0, 3));
            len  = 8'($urandom_range(0, 3) * 3);
            @(posedge clk);
            m_step();
            #1;
            chk_out($sformatf("rnd%0d", c), m_ph, (m_ph == 1) ? (1 << m_idx) : 0, m_idx,
                    (m_ph == 0 || m_ph == 1 || m_ph == 4) ? m_cnt : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
